text_write_scheduler: RTL and testbench
=======================================

Name: text_write_scheduler

Overview:
- Sequences all writes into the character plane write port (char/col/row/we) of the VGA text output path.
- Arbitrates two byte-stream requesters (A: keyboard path, B: serial path) with a valid/ready handshake.
- Tracks the cursor and interprets control codes: CR/LF, backspace, form-feed clear.
- Emits one plane write per accepted printable byte, or a full-screen clear sweep.

Parameters:
COLS, 40, characters per row (max 64; fits 6-bit column)
ROWS, 15, rows per screen (max 16; fits 4-bit row)

Ports:
clk  in  1  system clock; all state on rising edge
reset  in  1  asynchronous, active-high reset
a_data  in  8  requester A byte
a_valid  in  1  A has a byte; data held stable until accepted
a_ready  out  1  A byte accepted this cycle when a_valid&a_ready
b_data  in  8  requester B byte
b_valid  in  1  B has a byte; held until accepted
b_ready  out  1  B byte accepted when b_valid&b_ready
wr_char  out  8  character to plane
wr_col  out  6  target column
wr_row  out  4  target row
wr_en  out  1  plane write strobe, one cycle per cell
cur_col  out  6  current cursor column
cur_row  out  4  current cursor row
busy  out  1  high when state != IDLE

Behaviour:
- Reset (async, any state incl. mid-clear): state=IDLE; wr_en=0; wr_char=0; wr_col=0; wr_row=0; cur_col=0; cur_row=0; last_grant=B. Any clear in progress is aborted; no further writes.
- States: IDLE, HOLD, CLEAR.
- IDLE, ready outputs (combinational):
  - Only A valid -> a_ready=1. Only B valid -> b_ready=1.
  - Both valid -> grant the requester not equal to last_grant (round-robin). First contention after reset goes to A.
  - Exactly one ready high at a time. Both ready low outside IDLE.
- Accept at edge k: last_grant updated; byte decoded at the same edge:
  - 0x20..0x7E: wr_en=1, wr_char=byte, wr_col/wr_row=cursor. Cursor advances col+1. At col=COLS-1: col=0, row+1. At row=ROWS-1 with col=COLS-1: wraps to (0,0); no scroll. Next state HOLD.
  - 0x0D or 0x0A: no write; col=0, row+1 (row ROWS-1 wraps to 0). Next state HOLD.
  - 0x08: if col>0, col-1. Else if row>0, go to (row-1, COLS-1). Then write 0x20 at the new position (wr_en=1). At (0,0): no write, no move. Next state HOLD.
  - 0x0C: no write at k; next state CLEAR, sweep counter=(0,0).
  - All other bytes: ignored, consumed. Next state HOLD.
- HOLD: one cycle with wr_en=0 and readies low, then IDLE. Maximum throughput is one byte per 2 cycles.
- CLEAR: wr_en=1 each cycle with wr_char=0x20, addressing row-major (0,0)..(ROWS-1,COLS-1). This is exactly ROWS*COLS strobes (600 by default). After the last strobe: wr_en=0, cursor=(0,0), state=IDLE.
- wr_en is registered and high for exactly one cycle per write outside CLEAR. wr_* hold their last value when wr_en=0.
- Arithmetic: cursor compare uses COLS-1/ROWS-1. Column and row never exceed COLS-1/ROWS-1.

Test Plan:
- Reset, then A sends 0x41 -> a_ready high the accept cycle; next cycle wr_en=1, wr_char=0x41, (row0,col0); cursor=(0,1); busy=1 for 1 cycle.
- A and B both valid continuously with 0x31/0x32 -> accepts alternate A,B,A,B (A first); wr_en every 2nd cycle at cols 0,1,2,3.
- Cursor at (14,39), write 0x5A -> write at (14,39), cursor wraps to (0,0). Then 0x0D at (3,17) -> cursor (4,0) with no wr_en.
- Backspace at (2,0) -> cursor (1,39), write 0x20 at (1,39). Backspace at (0,0) -> no wr_en, cursor unchanged.
- 0x0C -> 600 consecutive wr_en pulses, first at (0,0), last at (14,39), all char 0x20; readies low throughout; then cursor (0,0) and busy=0.
- Assert reset after 100 clear strobes -> wr_en drops immediately, cursor (0,0), IDLE. Next A byte 0x42 is written at (0,0).

Source files
------------

// File: rtl/text_write_scheduler.sv
// Sequences character-plane writes for the text path: arbitrates two byte streams, tracks the cursor, runs clear sweeps.
// One registered write per accepted byte (1 cycle); readies only in IDLE, so a requester stalls through HOLD and the whole clear sweep.
module text_write_scheduler #(
  parameter int COLS = 40,
  parameter int ROWS = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] a_data,
  input  logic       a_valid,
  output logic       a_ready,
  input  logic [7:0] b_data,
  input  logic       b_valid,
  output logic       b_ready,
  output logic [7:0] wr_char,
  output logic [5:0] wr_col,
  output logic [3:0] wr_row,
  output logic       wr_en,
  output logic [5:0] cur_col,
  output logic [3:0] cur_row,
  output logic       busy
);

  localparam logic [5:0] COL_MAX = 6'(COLS - 1);
  localparam logic [3:0] ROW_MAX = 4'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, HOLD, CLEAR} state_t;

  typedef struct packed {
    logic [3:0] row;
    logic [5:0] col;
  } pos_t;

  typedef struct packed {
    logic       en;
    logic [7:0] chr;
    pos_t       pos;
  } wr_t;

  state_t state, state_nxt;
  wr_t    wr, wr_nxt;
  pos_t   cur, cur_nxt;
  pos_t   sweep, sweep_nxt;
  logic   clear_done, clear_done_nxt;
  logic   last_grant_b, last_grant_b_nxt;
  logic [7:0] byte_in;

  // Row-major step with wrap at the bottom-right corner (no scrolling).
  function automatic pos_t advance(input pos_t p);
    pos_t n;
    n = p;
    if (p.col == COL_MAX) begin
      n.col = '0;
      n.row = (p.row == ROW_MAX) ? '0 : p.row + 4'd1;
    end else begin
      n.col = p.col + 6'd1;
    end
    return n;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      wr           <= '0;
      cur          <= '0;
      sweep        <= '0;
      clear_done   <= 1'b0;
      last_grant_b <= 1'b1;
    end else begin
      state        <= state_nxt;
      wr           <= wr_nxt;
      cur          <= cur_nxt;
      sweep        <= sweep_nxt;
      clear_done   <= clear_done_nxt;
      last_grant_b <= last_grant_b_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    wr_nxt           = wr;
    wr_nxt.en        = 1'b0;
    cur_nxt          = cur;
    sweep_nxt        = sweep;
    clear_done_nxt   = clear_done;
    last_grant_b_nxt = last_grant_b;
    a_ready          = 1'b0;
    b_ready          = 1'b0;
    byte_in          = 8'h00;

    case (state)
      IDLE: begin
        // Under contention the side that did not win last time gets the grant.
        a_ready = a_valid && (!b_valid || last_grant_b);
        b_ready = b_valid && (!a_valid || !last_grant_b);
        if (a_ready || b_ready) begin
          last_grant_b_nxt = b_ready;
          byte_in          = b_ready ? b_data : a_data;
          state_nxt        = HOLD;
          if (byte_in >= 8'h20 && byte_in <= 8'h7E) begin
            wr_nxt.en  = 1'b1;
            wr_nxt.chr = byte_in;
            wr_nxt.pos = cur;
            cur_nxt    = advance(cur);
          end else if (byte_in == 8'h0D || byte_in == 8'h0A) begin
            cur_nxt.col = '0;
            cur_nxt.row = (cur.row == ROW_MAX) ? '0 : cur.row + 4'd1;
          end else if (byte_in == 8'h08) begin
            if (cur.col != '0 || cur.row != '0) begin
              if (cur.col != '0) begin
                cur_nxt.col = cur.col - 6'd1;
              end else begin
                cur_nxt.col = COL_MAX;
                cur_nxt.row = cur.row - 4'd1;
              end
              wr_nxt.en  = 1'b1;
              wr_nxt.chr = 8'h20;
              wr_nxt.pos = cur_nxt;
            end
          end else if (byte_in == 8'h0C) begin
            state_nxt      = CLEAR;
            sweep_nxt      = '0;
            clear_done_nxt = 1'b0;
          end
        end
      end

      HOLD: state_nxt = IDLE;

      CLEAR: begin
        // Stay in CLEAR while the final strobe is on the bus so readies stay low.
        if (clear_done) begin
          state_nxt      = IDLE;
          cur_nxt        = '0;
          clear_done_nxt = 1'b0;
        end else begin
          wr_nxt.en  = 1'b1;
          wr_nxt.chr = 8'h20;
          wr_nxt.pos = sweep;
          if (sweep.col == COL_MAX && sweep.row == ROW_MAX) begin
            clear_done_nxt = 1'b1;
          end else begin
            sweep_nxt = advance(sweep);
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign wr_en   = wr.en;
  assign wr_char = wr.chr;
  assign wr_col  = wr.pos.col;
  assign wr_row  = wr.pos.row;
  assign cur_col = cur.col;
  assign cur_row = cur.row;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_text_write_scheduler.sv
// Directed bench for text_write_scheduler: arbitration, cursor control codes, clear sweep, reset abort.
module tb_text_write_scheduler;

  logic       clk;
  logic       reset;
  logic [7:0] a_data, b_data;
  logic       a_valid, b_valid;
  logic       a_ready, b_ready;
  logic [7:0] wr_char;
  logic [5:0] wr_col;
  logic [3:0] wr_row;
  logic       wr_en;
  logic [5:0] cur_col;
  logic [3:0] cur_row;
  logic       busy;

  int passes = 0;
  int fails  = 0;
  int total  = 0;

  text_write_scheduler #(.COLS(40), .ROWS(15)) dut (
    .clk     (clk),
    .reset   (reset),
    .a_data  (a_data),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .b_data  (b_data),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .wr_char (wr_char),
    .wr_col  (wr_col),
    .wr_row  (wr_row),
    .wr_en   (wr_en),
    .cur_col (cur_col),
    .cur_row (cur_row),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic en, input logic [7:0] ch,
                        input logic [5:0] col, input logic [3:0] row);
    chk({tag, "_en"}, 32'(wr_en), 32'(en));
    chk({tag, "_char"}, 32'(wr_char), 32'(ch));
    chk({tag, "_col"}, 32'(wr_col), 32'(col));
    chk({tag, "_row"}, 32'(wr_row), 32'(row));
  endtask

  task automatic chk_cur(input string tag, input logic [5:0] col, input logic [3:0] row);
    chk({tag, "_cur_col"}, 32'(cur_col), 32'(col));
    chk({tag, "_cur_row"}, 32'(cur_row), 32'(row));
  endtask

  // Presents one byte, waits (bounded) for its ready, returns just after the accept edge.
  task automatic send(input bit use_b, input logic [7:0] d);
    int n;
    n = 0;
    if (use_b) begin b_valid = 1'b1; b_data = d; end
    else       begin a_valid = 1'b1; a_data = d; end
    #1;
    while (!(use_b ? b_ready : a_ready) && n < 20) begin
      tick();
      n++;
    end
    chk("send_ready_timeout", 32'(n < 20), 32'd1);
    tick();
    if (use_b) b_valid = 1'b0;
    else       a_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    int cnt, seq_err, rdy_err, r, c;
    reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0; a_data = 8'h00; b_data = 8'h00;
    #12;
    chk_wr("rst", 1'b0, 8'h00, 6'd0, 4'd0);
    chk_cur("rst", 6'd0, 4'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_a_ready", 32'(a_ready), 32'd0);
    reset = 1'b0;

    // Single printable byte from A
    a_valid = 1'b1; a_data = 8'h41;
    #1;
    chk("first_a_ready", 32'(a_ready), 32'd1);
    chk("first_b_ready", 32'(b_ready), 32'd0);
    tick();
    a_valid = 1'b0;
    chk_wr("first_wr", 1'b1, 8'h41, 6'd0, 4'd0);
    chk_cur("first", 6'd1, 4'd0);
    chk("first_busy", 32'(busy), 32'd1);
    tick();
    chk_wr("first_hold", 1'b0, 8'h41, 6'd0, 4'd0);
    chk("first_busy_after", 32'(busy), 32'd0);

    // Continuous contention: A, B, A, B with a write every second cycle
    tick();
    pulse_reset();
    a_valid = 1'b1; a_data = 8'h31; b_valid = 1'b1; b_data = 8'h32;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("arb_a_ready", 32'(a_ready), 32'(i % 2 == 0));
      chk("arb_b_ready", 32'(b_ready), 32'(i % 2 == 1));
      tick();
      chk_wr("arb_wr", 1'b1, (i % 2 == 0) ? 8'h31 : 8'h32, 6'(i), 4'd0);
      chk("arb_hold_rdy", 32'({a_ready, b_ready}), 32'd0);
      if (i == 3) begin a_valid = 1'b0; b_valid = 1'b0; end
      tick();
      chk("arb_gap_en", 32'(wr_en), 32'd0);
    end
    chk_cur("arb", 6'd4, 4'd0);

    // Bottom-right wrap
    for (int i = 0; i < 14; i++) send(1'b1, 8'h0A);
    chk_cur("lf14", 6'd0, 4'd14);
    for (int i = 0; i < 39; i++) send(1'b0, 8'h2E);
    chk_cur("corner", 6'd39, 4'd14);
    send(1'b0, 8'h5A);
    chk_wr("wrap_wr", 1'b1, 8'h5A, 6'd39, 4'd14);
    chk_cur("wrap", 6'd0, 4'd0);

    // CR mid-screen
    for (int i = 0; i < 3; i++) send(1'b1, 8'h0A);
    for (int i = 0; i < 17; i++) send(1'b1, 8'h2D);
    chk_cur("pre_cr", 6'd17, 4'd3);
    send(1'b1, 8'h0D);
    chk("cr_en", 32'(wr_en), 32'd0);
    chk_cur("cr", 6'd0, 4'd4);
    send(1'b0, 8'h07);
    chk("bel_en", 32'(wr_en), 32'd0);
    chk_cur("bel", 6'd0, 4'd4);
    send(1'b1, 8'h7F);
    chk("del_en", 32'(wr_en), 32'd0);
    chk_cur("del", 6'd0, 4'd4);

    // Backspace across a row boundary, within a row, and at home
    pulse_reset();
    send(1'b0, 8'h0A);
    send(1'b0, 8'h0A);
    send(1'b0, 8'h08);
    chk_wr("bs_row", 1'b1, 8'h20, 6'd39, 4'd1);
    chk_cur("bs_row", 6'd39, 4'd1);
    send(1'b1, 8'h08);
    chk_wr("bs_col", 1'b1, 8'h20, 6'd38, 4'd1);
    chk_cur("bs_col", 6'd38, 4'd1);
    pulse_reset();
    send(1'b0, 8'h08);
    chk("bs_home_en", 32'(wr_en), 32'd0);
    chk_cur("bs_home", 6'd0, 4'd0);

    // Full clear sweep with B waiting throughout
    send(1'b0, 8'h51);
    send(1'b0, 8'h0C);
    b_valid = 1'b1; b_data = 8'h41;
    chk("clr_k_en", 32'(wr_en), 32'd0);
    chk("clr_k_busy", 32'(busy), 32'd1);
    chk("clr_k_b_ready", 32'(b_ready), 32'd0);
    cnt = 0; seq_err = 0; rdy_err = 0; r = 0; c = 0;
    for (int i = 0; i < 700; i++) begin
      tick();
      if (!busy) break;
      if (!wr_en || wr_char !== 8'h20 || wr_col !== 6'(c) || wr_row !== 4'(r)) seq_err++;
      if (a_ready || b_ready) rdy_err++;
      cnt++;
      c++;
      if (c == 40) begin c = 0; r++; end
    end
    chk("clr_strobes", 32'(cnt), 32'd600);
    chk("clr_seq_err", 32'(seq_err), 32'd0);
    chk("clr_rdy_err", 32'(rdy_err), 32'd0);
    chk_wr("clr_done", 1'b0, 8'h20, 6'd39, 4'd14);
    chk_cur("clr_done", 6'd0, 4'd0);
    chk("clr_done_b_ready", 32'(b_ready), 32'd1);
    tick();
    b_valid = 1'b0;
    chk_wr("post_clr_wr", 1'b1, 8'h41, 6'd0, 4'd0);
    chk_cur("post_clr", 6'd1, 4'd0);
    tick();

    // Reset during a sweep
    send(1'b0, 8'h0C);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (wr_en) cnt++;
    end
    chk("abort_strobes", 32'(cnt), 32'd100);
    #1;
    reset = 1'b1;
    #1;
    chk_wr("abort", 1'b0, 8'h00, 6'd0, 4'd0);
    chk_cur("abort", 6'd0, 4'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (wr_en) cnt++;
    end
    chk("abort_no_writes", 32'(cnt), 32'd0);
    send(1'b0, 8'h42);
    chk_wr("abort_next", 1'b1, 8'h42, 6'd0, 4'd0);
    chk_cur("abort_next", 6'd1, 4'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
